// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the parametrised LFSR generator.
// FSM encoding plus the classic 16-bit taps and seed.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOCK = 2'd2
  } lfsr_st_e;

  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'h0001;

endpackage

// File: rtl/lfsr_stats.sv
// Saturating ones/zeros/period statistics for lfsr_gen.
// A clear drops the bit of the shift that coincides with it.
module lfsr_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift,
  input  logic             sbit,
  input  logic             clr,
  input  logic             clr_period,
  input  logic             wrap,
  output logic [CNT_W-1:0] ones,
  output logic [CNT_W-1:0] zeros,
  output logic [CNT_W-1:0] period
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] pcnt_inc;

  assign pcnt_inc = (pcnt == MAX) ? MAX : pcnt + ONE;

  // counters: clear wins, else count the shifted bit and cycle length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ones   <= '0;
      zeros  <= '0;
      pcnt   <= '0;
      period <= '0;
    end else if (clr) begin
      ones  <= '0;
      zeros <= '0;
      pcnt  <= '0;
      if (clr_period)
        period <= '0;
    end else if (shift) begin
      if (sbit) begin
        if (ones != MAX)
          ones <= ones + ONE;
      end else begin
        if (zeros != MAX)
          zeros <= zeros + ONE;
      end
      if (wrap) begin
        period <= pcnt_inc;
        pcnt   <= '0;
      end else begin
        pcnt <= pcnt_inc;
      end
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, lockup detect,
// bit statistics, measured period and registered wrap tick.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sh_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_stats,
  output logic [WIDTH-1:0] Q_out,
  output logic             sout,
  output logic [CNT_W-1:0] ones,
  output logic [CNT_W-1:0] zeros,
  output logic [CNT_W-1:0] period,
  output logic             max_tick_reg,
  output logic             lock_err
);

  lfsr_st_e         st;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] q_nxt;
  logic             fb;
  logic             do_shift;
  logic             wrap;

  assign fb       = ^(q & TAPS);
  assign q_nxt    = {q[WIDTH-2:0], fb};
  assign do_shift = sh_en && !load && (st != ST_LOCK);
  assign wrap     = do_shift && (q_nxt == ref_q);

  assign Q_out = q;
  assign sout  = q[WIDTH-1];

  // state register, load/lock handling and wrap tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st           <= ST_IDLE;
      q            <= SEED;
      ref_q        <= SEED;
      max_tick_reg <= 1'b0;
      lock_err     <= 1'b0;
    end else begin
      max_tick_reg <= wrap;
      if (load) begin
        q     <= load_val;
        ref_q <= load_val;
        if (load_val == '0) begin
          st       <= ST_LOCK;
          lock_err <= 1'b1;
        end else begin
          st       <= ST_RUN;
          lock_err <= 1'b0;
        end
      end else begin
        unique case (st)
          ST_IDLE: begin
            if (sh_en) begin
              st <= ST_RUN;
              q  <= q_nxt;
            end
          end
          ST_RUN: begin
            if (sh_en)
              q <= q_nxt;
          end
          ST_LOCK: begin
            q <= q;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

  lfsr_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .reset_n   (reset_n),
    .shift     (do_shift),
    .sbit      (q[WIDTH-1]),
    .clr       (load | clr_stats),
    .clr_period(load),
    .wrap      (wrap),
    .ones      (ones),
    .zeros     (zeros),
    .period    (period)
  );

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 16-bit instance,
// a 4-bit maximal instance and a 4-bit-counter instance.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sh_en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        clr_stats = 1'b0;
  logic [3:0]  lv4;

  logic [15:0] q;
  logic        sout;
  logic [31:0] ones, zeros, period;
  logic        tick, lock;

  logic [3:0]  s_q;
  logic        s_sout;
  logic [7:0]  s_ones, s_zeros, s_period;
  logic        s_tick, s_lock;

  logic [15:0] c_q;
  logic        c_sout;
  logic [3:0]  c_ones, c_zeros, c_period;
  logic        c_tick, c_lock;

  int n_chk = 0;
  int n_fail = 0;

  assign lv4 = load_val[3:0];

  always #5 clk = ~clk;

  lfsr_gen u_dut (
    .clk(clk), .reset_n(reset_n), .sh_en(sh_en),
    .load(load), .load_val(load_val),
    .clr_stats(clr_stats), .Q_out(q), .sout(sout),
    .ones(ones), .zeros(zeros), .period(period),
    .max_tick_reg(tick), .lock_err(lock)
  );

  lfsr_gen #(
    .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .CNT_W(8)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .sh_en(sh_en),
    .load(load), .load_val(lv4),
    .clr_stats(clr_stats), .Q_out(s_q), .sout(s_sout),
    .ones(s_ones), .zeros(s_zeros), .period(s_period),
    .max_tick_reg(s_tick), .lock_err(s_lock)
  );

  lfsr_gen #(
    .CNT_W(4)
  ) u_sat (
    .clk(clk), .reset_n(reset_n), .sh_en(sh_en),
    .load(load), .load_val(load_val),
    .clr_stats(clr_stats), .Q_out(c_q), .sout(c_sout),
    .ones(c_ones), .zeros(c_zeros), .period(c_period),
    .max_tick_reg(c_tick), .lock_err(c_lock)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    sh_en = 0; load = 0; clr_stats = 0;
    do_reset();
    n_chk++;
    if (q !== 16'h0001) begin
      n_fail++;
      $display("FAIL reset_q got %h want 0001", q);
    end
    n_chk++;
    if (ones !== 0 || zeros !== 0 || period !== 0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0",
               ones, zeros, period);
    end
    n_chk++;
    if (tick !== 1'b0 || lock !== 1'b0 || sout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b%b%b want 000",
               tick, lock, sout);
    end
    step();
    n_chk++;
    if (q !== 16'h0001) begin
      n_fail++;
      $display("FAIL idle_hold got %h want 0001", q);
    end
  endtask

  task automatic test_shift();
    logic [15:0] exp;
    sh_en = 1;
    for (int i = 1; i <= 11; i++) begin
      step();
      exp = (i <= 10) ? (16'h0001 << i) : 16'h0801;
      n_chk++;
      if (q !== exp) begin
        n_fail++;
        $display("FAIL shift_%0d got %h want %h", i, q, exp);
      end
    end
    n_chk++;
    if (ones !== 0 || zeros !== 11) begin
      n_fail++;
      $display("FAIL shift_cnt got %0d/%0d want 0/11",
               ones, zeros);
    end
    sh_en = 0;
  endtask

  task automatic test_full_cycle();
    int ticks;
    int at;
    ticks = 0;
    at = -1;
    do_reset();
    sh_en = 1;
    for (int i = 1; i <= 65535; i++) begin
      step();
      if (tick === 1'b1) begin
        ticks++;
        at = i;
      end
    end
    n_chk++;
    if (q !== 16'h0001 || tick !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_q got %h/%b want 0001/1", q, tick);
    end
    n_chk++;
    if (ticks !== 1 || at !== 65535) begin
      n_fail++;
      $display("FAIL wrap_ticks got %0d@%0d want 1@65535",
               ticks, at);
    end
    n_chk++;
    if (period !== 65535) begin
      n_fail++;
      $display("FAIL wrap_period got %0d want 65535", period);
    end
    n_chk++;
    if (ones !== 32768 || zeros !== 32767) begin
      n_fail++;
      $display("FAIL wrap_stats got %0d/%0d want 32768/32767",
               ones, zeros);
    end
    step();
    n_chk++;
    if (tick !== 1'b0 || q !== 16'h0002) begin
      n_fail++;
      $display("FAIL wrap_after got %b/%h want 0/0002", tick, q);
    end
    sh_en = 0;
  endtask

  task automatic test_load();
    sh_en = 1;
    load = 1;
    load_val = 16'hACE1;
    step();
    load = 0;
    n_chk++;
    if (q !== 16'hACE1 || sout !== 1'b1) begin
      n_fail++;
      $display("FAIL load_q got %h/%b want ace1/1", q, sout);
    end
    n_chk++;
    if (ones !== 0 || zeros !== 0 || period !== 0) begin
      n_fail++;
      $display("FAIL load_cnt got %0d/%0d/%0d want 0/0/0",
               ones, zeros, period);
    end
    step();
    n_chk++;
    if (q !== 16'h59C3 || ones !== 1 || zeros !== 0) begin
      n_fail++;
      $display("FAIL load_next got %h/%0d/%0d want 59c3/1/0",
               q, ones, zeros);
    end
    sh_en = 0;
  endtask

  task automatic test_small_wrap();
    sh_en = 1;
    load = 1;
    load_val = 16'h000A;
    step();
    load = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      n_chk++;
      if (s_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL small_early_%0d got %b want 0", i, s_tick);
      end
    end
    step();
    n_chk++;
    if (s_q !== 4'hA || s_tick !== 1'b1 || s_period !== 15) begin
      n_fail++;
      $display("FAIL small_wrap got %h/%b/%0d want a/1/15",
               s_q, s_tick, s_period);
    end
    n_chk++;
    if (s_ones !== 8 || s_zeros !== 7) begin
      n_fail++;
      $display("FAIL small_stats got %0d/%0d want 8/7",
               s_ones, s_zeros);
    end
    sh_en = 0;
  endtask

  task automatic test_lock();
    sh_en = 1;
    load = 1;
    load_val = 16'h0000;
    step();
    load = 0;
    n_chk++;
    if (lock !== 1'b1 || q !== 16'h0000) begin
      n_fail++;
      $display("FAIL lock_set got %b/%h want 1/0000", lock, q);
    end
    for (int i = 0; i < 3; i++)
      step();
    n_chk++;
    if (lock !== 1'b1 || q !== 16'h0000 || zeros !== 0) begin
      n_fail++;
      $display("FAIL lock_hold got %b/%h/%0d want 1/0000/0",
               lock, q, zeros);
    end
    load = 1;
    load_val = 16'h0001;
    step();
    load = 0;
    n_chk++;
    if (lock !== 1'b0 || q !== 16'h0001) begin
      n_fail++;
      $display("FAIL lock_exit got %b/%h want 0/0001", lock, q);
    end
    step();
    n_chk++;
    if (q !== 16'h0002) begin
      n_fail++;
      $display("FAIL lock_resume got %h want 0002", q);
    end
    sh_en = 0;
  endtask

  task automatic test_toggle();
    logic [15:0] prev;
    load = 1;
    load_val = 16'h0001;
    step();
    load = 0;
    for (int i = 0; i < 20; i++) begin
      prev = q;
      sh_en = (i % 2 == 0);
      step();
      if (i % 2 == 1) begin
        n_chk++;
        if (q !== prev) begin
          n_fail++;
          $display("FAIL toggle_hold_%0d got %h want %h",
                   i, q, prev);
        end
      end
    end
    n_chk++;
    if (q !== 16'h0400 || ones + zeros !== 10 || zeros !== 10) begin
      n_fail++;
      $display("FAIL toggle_end got %h/%0d/%0d want 0400/0/10",
               q, ones, zeros);
    end
    sh_en = 1;
    clr_stats = 1;
    step();
    clr_stats = 0;
    sh_en = 0;
    n_chk++;
    if (q !== 16'h0801 || ones !== 0 || zeros !== 0) begin
      n_fail++;
      $display("FAIL clr_shift got %h/%0d/%0d want 0801/0/0",
               q, ones, zeros);
    end
  endtask

  task automatic test_async_reset_sat();
    sh_en = 1;
    for (int i = 0; i < 5; i++)
      step();
    #3;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (q !== 16'h0001 || zeros !== 0 || c_zeros !== 0) begin
      n_fail++;
      $display("FAIL async_rst got %h/%0d/%0d want 0001/0/0",
               q, zeros, c_zeros);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++)
      step();
    n_chk++;
    if (c_zeros !== 4'd15 || c_ones !== 4'd1) begin
      n_fail++;
      $display("FAIL sat_cnt got %0d/%0d want 15/1",
               c_zeros, c_ones);
    end
    n_chk++;
    if (zeros !== 19 || ones !== 1) begin
      n_fail++;
      $display("FAIL wide_cnt got %0d/%0d want 19/1", zeros, ones);
    end
    sh_en = 0;
  endtask

  initial begin
    test_reset();
    test_shift();
    test_full_cycle();
    test_load();
    test_small_wrap();
    test_lock();
    test_toggle();
    test_async_reset_sat();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
